// File: rtl/fp_mul_pipe_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  localparam int FLAGS_W  = 3;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // All-ones exponent code: reserved for inf/NaN.
  function automatic int exp_max_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_round_rne.sv
// Round-to-nearest-even on a normalised mantissa (hidden bit included).
// A carry out of the mantissa bumps the exponent; the stored bits wrap to 0,
// which is exactly the mantissa of the next binade.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int MAN_W = 10,
  parameter int SEW   = 7
) (
  input  logic [MAN_W:0]   i_man,
  input  logic             i_guard,
  input  logic             i_sticky,
  input  logic [SEW-1:0]   i_exp,
  output logic [MAN_W-1:0] o_man,
  output logic [SEW-1:0]   o_exp
);

  logic inc;
  logic carry;

  // Increment on more than half, or exactly half with an odd lsb.
  always_comb begin
    inc   = i_guard & (i_sticky | i_man[0]);
    carry = inc & (&i_man);
    o_man = i_man[MAN_W-1:0] + MAN_W'(inc);
    o_exp = i_exp + SEW'(carry);
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-style multiplier with valid/ready handshake.
// S1 unpacks and multiplies, S2 normalises and rounds, S3 range-checks,
// applies special cases and holds the packed result for the consumer.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_res,
  output logic [2:0]   o_flags
);

  localparam int BIAS    = bias_of(EXP_W);
  localparam int EXP_MAX = exp_max_of(EXP_W);
  localparam int SEW     = EXP_W + 2;
  localparam int PW      = 2 * (MAN_W + 1);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;
    if (e == '1) return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

  logic ld1, ld2, ld3;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;

  logic             s1_sign_q, s1_sign_d;
  fp_class_e        s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
  logic [SEW-1:0]   s1_exp_q, s1_exp_d;
  logic [PW-1:0]    s1_prod_q, s1_prod_d;

  logic             s2_sign_q, s2_sign_d;
  fp_class_e        s2_cls_a_q, s2_cls_a_d, s2_cls_b_q, s2_cls_b_d;
  logic [SEW-1:0]   s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0] s2_man_q, s2_man_d;

  logic [W-1:0]     s3_res_q, s3_res_d;
  logic [2:0]       s3_flags_q, s3_flags_d;

  logic [MAN_W:0]   nrm_man;
  logic             nrm_guard, nrm_sticky;
  logic [SEW-1:0]   nrm_exp, rnd_exp;
  logic [MAN_W-1:0] rnd_man;
  logic             sp_nan, sp_inf, sp_zero;

  // Handshake: a stage loads when empty or when its successor takes its data.
  always_comb begin
    ld3     = s2_v_q & (~s3_v_q | i_ready);
    ld2     = s1_v_q & (~s2_v_q | ld3);
    o_ready = ~s1_v_q | ld2;
    ld1     = i_valid & o_ready;
    s1_v_d  = ld1 | (s1_v_q & ~ld2);
    s2_v_d  = ld2 | (s2_v_q & ~ld3);
    s3_v_d  = ld3 | (s3_v_q & ~i_ready);
  end

  // S1: classify operands, biased exponent sum, full mantissa product.
  always_comb begin
    s1_sign_d  = s1_sign_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    s1_exp_d   = s1_exp_q;
    s1_prod_d  = s1_prod_q;
    if (ld1) begin
      s1_sign_d  = i_a[W-1] ^ i_b[W-1];
      s1_cls_a_d = classify(i_a[W-2 -: EXP_W], i_a[MAN_W-1:0]);
      s1_cls_b_d = classify(i_b[W-2 -: EXP_W], i_b[MAN_W-1:0]);
      s1_exp_d   = SEW'(i_a[W-2 -: EXP_W]) + SEW'(i_b[W-2 -: EXP_W]) - SEW'(BIAS);
      s1_prod_d  = PW'({1'b1, i_a[MAN_W-1:0]}) * PW'({1'b1, i_b[MAN_W-1:0]});
    end
  end

  // S2 front half: product in [1,4) normalised to [1,2) with guard/sticky.
  always_comb begin
    if (s1_prod_q[PW-1]) begin
      nrm_man    = s1_prod_q[PW-1 -: MAN_W+1];
      nrm_guard  = s1_prod_q[MAN_W];
      nrm_sticky = |s1_prod_q[MAN_W-1:0];
      nrm_exp    = s1_exp_q + SEW'(1);
    end else begin
      nrm_man    = s1_prod_q[PW-2 -: MAN_W+1];
      nrm_guard  = s1_prod_q[MAN_W-1];
      nrm_sticky = |s1_prod_q[MAN_W-2:0];
      nrm_exp    = s1_exp_q;
    end
  end

  fp_round_rne #(.MAN_W(MAN_W), .SEW(SEW)) u_round (
    .i_man    (nrm_man),
    .i_guard  (nrm_guard),
    .i_sticky (nrm_sticky),
    .i_exp    (nrm_exp),
    .o_man    (rnd_man),
    .o_exp    (rnd_exp)
  );

  // S2: capture the rounded magnitude alongside the operand classes.
  always_comb begin
    s2_sign_d  = s2_sign_q;
    s2_cls_a_d = s2_cls_a_q;
    s2_cls_b_d = s2_cls_b_q;
    s2_exp_d   = s2_exp_q;
    s2_man_d   = s2_man_q;
    if (ld2) begin
      s2_sign_d  = s1_sign_q;
      s2_cls_a_d = s1_cls_a_q;
      s2_cls_b_d = s1_cls_b_q;
      s2_exp_d   = rnd_exp;
      s2_man_d   = rnd_man;
    end
  end

  // S3: special operands override the arithmetic, then range check and pack.
  always_comb begin
    sp_nan  = (s2_cls_a_q == NAN) | (s2_cls_b_q == NAN) |
              ((s2_cls_a_q == INF) & (s2_cls_b_q == ZERO)) |
              ((s2_cls_a_q == ZERO) & (s2_cls_b_q == INF));
    sp_inf  = (s2_cls_a_q == INF) | (s2_cls_b_q == INF);
    sp_zero = (s2_cls_a_q == ZERO) | (s2_cls_b_q == ZERO);
    s3_res_d   = s3_res_q;
    s3_flags_d = s3_flags_q;
    if (ld3) begin
      s3_flags_d = '0;
      if (sp_nan) begin
        s3_res_d             = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        s3_flags_d[FLAG_INV] = 1'b1;
      end else if (sp_inf) begin
        s3_res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (sp_zero) begin
        s3_res_d = {s2_sign_q, {(W-1){1'b0}}};
      end else if (s2_exp_q[SEW-1] || (s2_exp_q == '0)) begin
        s3_res_d             = {s2_sign_q, {(W-1){1'b0}}};
        s3_flags_d[FLAG_UNF] = 1'b1;
      end else if (s2_exp_q >= SEW'(EXP_MAX)) begin
        s3_res_d             = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        s3_flags_d[FLAG_OVF] = 1'b1;
      end else begin
        s3_res_d = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_man_q};
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_a_q <= ZERO;
      s1_cls_b_q <= ZERO;
      s1_exp_q   <= '0;
      s1_prod_q  <= '0;
      s2_sign_q  <= 1'b0;
      s2_cls_a_q <= ZERO;
      s2_cls_b_q <= ZERO;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s3_res_q   <= '0;
      s3_flags_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s3_v_q     <= s3_v_d;
      s1_sign_q  <= s1_sign_d;
      s1_cls_a_q <= s1_cls_a_d;
      s1_cls_b_q <= s1_cls_b_d;
      s1_exp_q   <= s1_exp_d;
      s1_prod_q  <= s1_prod_d;
      s2_sign_q  <= s2_sign_d;
      s2_cls_a_q <= s2_cls_a_d;
      s2_cls_b_q <= s2_cls_b_d;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      s3_res_q   <= s3_res_d;
      s3_flags_q <= s3_flags_d;
    end
  end

  assign o_valid = s3_v_q;
  assign o_res   = s3_res_q;
  assign o_flags = s3_flags_q;

endmodule
